bpu_resolve_unit: RTL
=====================

BPU_RESOLVE_UNIT -- requirements
Module: bpu_resolve_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 30, word-address width.
REQ-002 SHALL have parameter H_WIDTH, default 14, branch-history width.
REQ-003 SHALL have parameter DEPTH, default 8, metadata queue depth (power of 2).
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rstn  in  1  reset; synchronous, active-low.
REQ-006 SHALL have port stall  in  1  freezes push, pop and FSM.
REQ-007 SHALL have port flush_in  in  1  external flush (exception/ertn).
REQ-008 SHALL have port pdc_valid  in  1  prediction metadata push request.
REQ-009 SHALL have port pdc_ready  out  1  queue accepts push.
REQ-010 SHALL have push payload inputs: pc_if, npc_pdc (ADDR_WIDTH); kind_pdc (3); taken_pdc (1); bh_pdc (H_WIDTH); choice_pdc (2); pdch (8).
REQ-011 SHALL have resolve inputs: br_valid (1), br_pc (ADDR_WIDTH), br_kind (3), br_taken (1), br_target (ADDR_WIDTH).
REQ-012 SHALL have predictor update outputs: update_en (1), pc_ex, npc_ex, ret_pc_ex (ADDR_WIDTH), mis_pdc (3; 2 npc, 1 kind, 0 taken), kind_ex (3), taken_real (1), bh_ex (H_WIDTH), choice_real, choice_pdc_ex (2), out_pdch (8).
REQ-013 SHALL have outputs redirect_valid (1), redirect_pc (ADDR_WIDTH), err_underflow (1), stat_total, stat_mis (32).

Function
REQ-014 SHALL push payload when pdc_valid && pdc_ready && !stall; pdc_ready = !full && state==NORMAL.
REQ-015 SHALL pop head when br_valid && !empty && !stall; br_valid with empty queue sets sticky err_underflow, nothing popped.
REQ-016 SHALL compute actual npc = br_taken ? br_target : br_pc+1 (mod 2^ADDR_WIDTH); ret_pc_ex = br_pc+1.
REQ-017 SHALL set mis_pdc[0] = taken_pdc!=br_taken, [1] = kind_pdc!=br_kind, [2] = npc_pdc!=actual npc.
REQ-018 SHALL set choice_real[0] = 1 if pdch[7]==br_taken && pdch[5]!=br_taken, 0 if reverse, else choice_pdc[0].
REQ-019 SHALL set choice_real[1] = choice_pdc[1]^mis_pdc[2] for br_kind RET/INDIRECT_JUMP, else choice_pdc[1].
REQ-020 SHALL register all update outputs; update_en pulses exactly 1 cycle after pop, outputs hold until next pop.
REQ-021 SHALL, when any mis_pdc bit set, pulse redirect_valid with update_en, redirect_pc = actual npc, clear queue at same edge, enter RECOVER.
REQ-022 SHALL, in RECOVER, hold pdc_ready=0 for one unstalled cycle, then return to NORMAL.
REQ-023 SHALL drop a same-cycle push when mispredicting pop or flush_in occurs.
REQ-024 SHALL, on flush_in, clear queue, suppress update_en/redirect, go NORMAL; flush_in beats pop.
REQ-025 SHALL use (log2 DEPTH)+1-bit pointers; full when MSBs differ and rest equal; simultaneous push+pop on full allowed only if pop frees slot same cycle is NOT assumed (push blocked when full).

Reset
REQ-026 SHALL on !rstn clear pointers, state=NORMAL, update_en=0, redirect_valid=0, err_underflow=0, stats=0, all data outputs 0.

Configuration
REQ-027 SHALL with BPU_RESOLVE_STATS_EN increment stat_total per update_en and stat_mis per update_en with mis_pdc!=0.
REQ-028 SHALL without BPU_RESOLVE_STATS_EN tie stat_total, stat_mis to 0 with no counter logic.

Structure
REQ-029 SHALL take kind codes (NOT_JUMP 0, DIRECT_JUMP 1, RET 4, INDIRECT_JUMP 5, CALL 6, JUMP 7), metadata entry struct and FSM state enum from shared package bpu_pkg.
REQ-030 SHALL implement queue as sub-module bpu_meta_fifo (push, pop, clear, full, empty).

Verification
REQ-031 Push {npc_pdc=0x100,taken=1,kind=1}; resolve br_pc=0xFF,br_taken=1,br_target=0x100 -> next cycle update_en=1, mis_pdc=000, no redirect.
REQ-032 Push taken_pdc=0, resolve br_taken=1,target=0x200 -> mis_pdc=101, redirect_pc=0x200, queue empty, pdc_ready=0 one cycle.
REQ-033 Push DEPTH entries -> pdc_ready=0; pop one -> pdc_ready=1 next cycle; pointer wrap after 2*DEPTH pushes keeps order.
REQ-034 br_valid on empty queue -> err_underflow=1 sticky, update_en=0; flush_in with push+pop same cycle -> queue empty, no update_en.
REQ-035 pdch=0x80,br_taken=1 -> choice_real[0]=1; stall held 3 cycles during br_valid -> no pop until stall drops.
REQ-036 With BPU_RESOLVE_STATS_EN, 4 resolves with 1 mispredict -> stat_total=4, stat_mis=1; rstn mid-run -> all zero.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared branch-predictor definitions: branch kind codes, queued metadata layout, resolve FSM states.
package bpu_pkg;

   localparam logic [2:0] KIND_NOT_JUMP      = 3'd0;
   localparam logic [2:0] KIND_DIRECT_JUMP   = 3'd1;
   localparam logic [2:0] KIND_RET           = 3'd4;
   localparam logic [2:0] KIND_INDIRECT_JUMP = 3'd5;
   localparam logic [2:0] KIND_CALL          = 3'd6;
   localparam logic [2:0] KIND_JUMP          = 3'd7;

   typedef enum logic {
      ST_NORMAL  = 1'b0,
      ST_RECOVER = 1'b1
   } rsv_state_t;

   // Fixed-width part of a queued prediction; address and history fields ride alongside it.
   typedef struct packed {
      logic [2:0] kind;
      logic       taken;
      logic [1:0] choice;
      logic [7:0] pdch;
   } meta_t;

   localparam int META_W = $bits(meta_t);

   function automatic logic is_indirect(input logic [2:0] kind);
      return (kind == KIND_RET) || (kind == KIND_INDIRECT_JUMP);
   endfunction

endpackage

// File: rtl/bpu_meta_fifo.sv
// Prediction metadata queue: head visible combinationally, push/pop take effect at the clock edge.
// Push ignored when full, pop ignored when empty; clear empties the queue and wins over push/pop.
module bpu_meta_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             clear,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic [WIDTH-1:0] mem [DEPTH];

   // Extra pointer bit distinguishes a full queue from an empty one.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign head  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full) begin
            wptr <= wptr + PTR_ONE;
         end
         if (pop && !empty) begin
            rptr <= rptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rstn && !clear && push && !full) begin
         mem[wptr[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/bpu_resolve_unit.sv
// Branch resolve: pops queued predictions, registers predictor update/redirect 1 cycle after pop.
// pdc_ready low when full or for one cycle after a redirect; optional counters via BPU_RESOLVE_STATS_EN.
module bpu_resolve_unit
   import bpu_pkg::*;
#(
   parameter int ADDR_WIDTH = 30,
   parameter int H_WIDTH    = 14,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  stall,
   input  logic                  flush_in,
   input  logic                  pdc_valid,
   output logic                  pdc_ready,
   input  logic [ADDR_WIDTH-1:0] pc_if,
   input  logic [ADDR_WIDTH-1:0] npc_pdc,
   input  logic [2:0]            kind_pdc,
   input  logic                  taken_pdc,
   input  logic [H_WIDTH-1:0]    bh_pdc,
   input  logic [1:0]            choice_pdc,
   input  logic [7:0]            pdch,
   input  logic                  br_valid,
   input  logic [ADDR_WIDTH-1:0] br_pc,
   input  logic [2:0]            br_kind,
   input  logic                  br_taken,
   input  logic [ADDR_WIDTH-1:0] br_target,
   output logic                  update_en,
   output logic [ADDR_WIDTH-1:0] pc_ex,
   output logic [ADDR_WIDTH-1:0] npc_ex,
   output logic [ADDR_WIDTH-1:0] ret_pc_ex,
   output logic [2:0]            mis_pdc,
   output logic [2:0]            kind_ex,
   output logic                  taken_real,
   output logic [H_WIDTH-1:0]    bh_ex,
   output logic [1:0]            choice_real,
   output logic [1:0]            choice_pdc_ex,
   output logic [7:0]            out_pdch,
   output logic                  redirect_valid,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  err_underflow,
   output logic [31:0]           stat_total,
   output logic [31:0]           stat_mis
);

   localparam int ENT_W = 2*ADDR_WIDTH + H_WIDTH + META_W;

   logic [ENT_W-1:0]      push_ent;
   logic [ENT_W-1:0]      head_ent;
   meta_t                 push_meta;
   meta_t                 h_meta;
   logic [ADDR_WIDTH-1:0] h_pc;
   logic [ADDR_WIDTH-1:0] h_npc;
   logic [H_WIDTH-1:0]    h_bh;

   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  mispred;
   logic                  clear;
   logic [ADDR_WIDTH-1:0] seq_pc;
   logic [ADDR_WIDTH-1:0] act_npc;
   logic [2:0]            mis;
   logic [1:0]            choice_nxt;

   rsv_state_t            state_q;
   rsv_state_t            state_d;

   always_comb begin
      push_meta        = '0;
      push_meta.kind   = kind_pdc;
      push_meta.taken  = taken_pdc;
      push_meta.choice = choice_pdc;
      push_meta.pdch   = pdch;
   end

   assign push_ent = {pc_if, npc_pdc, bh_pdc, push_meta};
   assign {h_pc, h_npc, h_bh, h_meta} = head_ent;

   bpu_meta_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_meta_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push),
      .push_data (push_ent),
      .pop       (pop),
      .clear     (clear),
      .head      (head_ent),
      .full      (full),
      .empty     (empty)
   );

   // Flush outranks a resolve in the same cycle: nothing is popped or reported.
   assign pop     = br_valid && !empty && !stall && !flush_in;
   assign seq_pc  = br_pc + ADDR_WIDTH'(1);
   assign act_npc = br_taken ? br_target : seq_pc;
   assign mis     = {h_npc != act_npc, h_meta.kind != br_kind, h_meta.taken != br_taken};
   assign mispred = pop && (mis != 3'b000);
   assign clear   = flush_in || mispred;
   assign push    = pdc_valid && pdc_ready && !stall && !clear;

   always_comb begin
      choice_nxt = h_meta.choice;
      if ((h_meta.pdch[7] == br_taken) && (h_meta.pdch[5] != br_taken)) begin
         choice_nxt[0] = 1'b1;
      end else if ((h_meta.pdch[7] != br_taken) && (h_meta.pdch[5] == br_taken)) begin
         choice_nxt[0] = 1'b0;
      end
      if (is_indirect(br_kind)) begin
         choice_nxt[1] = h_meta.choice[1] ^ mis[2];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_NORMAL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pdc_ready = !full && (state_q == ST_NORMAL);
      if (flush_in) begin
         state_d = ST_NORMAL;
      end else if (!stall) begin
         case (state_q)
            ST_NORMAL:  if (mispred) state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_NORMAL;
            default:    state_d = ST_NORMAL;
         endcase
      end
   end

   // Update fields hold their last value between pops; only the strobes return to zero.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         update_en      <= 1'b0;
         redirect_valid <= 1'b0;
         err_underflow  <= 1'b0;
         pc_ex          <= '0;
         npc_ex         <= '0;
         ret_pc_ex      <= '0;
         mis_pdc        <= '0;
         kind_ex        <= '0;
         taken_real     <= 1'b0;
         bh_ex          <= '0;
         choice_real    <= '0;
         choice_pdc_ex  <= '0;
         out_pdch       <= '0;
         redirect_pc    <= '0;
      end else begin
         update_en      <= pop;
         redirect_valid <= mispred;
         if (br_valid && empty && !stall) begin
            err_underflow <= 1'b1;
         end
         if (pop) begin
            pc_ex         <= h_pc;
            npc_ex        <= act_npc;
            ret_pc_ex     <= seq_pc;
            mis_pdc       <= mis;
            kind_ex       <= br_kind;
            taken_real    <= br_taken;
            bh_ex         <= h_bh;
            choice_real   <= choice_nxt;
            choice_pdc_ex <= h_meta.choice;
            out_pdch      <= h_meta.pdch;
            redirect_pc   <= act_npc;
         end
      end
   end

`ifdef BPU_RESOLVE_STATS_EN
   logic [31:0] total_q;
   logic [31:0] mis_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         total_q <= '0;
         mis_q   <= '0;
      end else if (update_en) begin
         total_q <= total_q + 32'd1;
         if (mis_pdc != 3'b000) begin
            mis_q <= mis_q + 32'd1;
         end
      end
   end

   assign stat_total = total_q;
   assign stat_mis   = mis_q;
`else
   assign stat_total = '0;
   assign stat_mis   = '0;
`endif

endmodule
